// File: rtl/cbus_arbiter_pkg.sv
// rtl/cbus_arbiter_pkg.sv - shared cache-bus types, arbiter states and defaults
package cbus_arbiter_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  // Beat count minus one, AXI-style.
  typedef enum logic [7:0] {
    MLEN1  = 8'd0,
    MLEN2  = 8'd1,
    MLEN4  = 8'd3,
    MLEN8  = 8'd7,
    MLEN16 = 8'd15
  } mlen_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_type_t;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    logic [63:0]     addr;
    msize_t          size;
    logic [7:0]      strobe;
    logic [63:0]     data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  localparam int NUM_REQ_DEFAULT = 2;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t ST_IDLE  = 1'b0;
  localparam arb_state_t ST_GRANT = 1'b1;

endpackage

// File: rtl/cbus_arbiter_rr_picker.sv
// rtl/cbus_arbiter_rr_picker.sv - combinational round-robin winner select
module cbus_arbiter_rr_picker
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
  input  logic [NUM_REQ-1:0]         valid_i,
  input  logic [$clog2(NUM_REQ)-1:0] prio_i,
  output logic [$clog2(NUM_REQ)-1:0] winner_o,
  output logic                       any_valid_o
);

  localparam int W = $clog2(NUM_REQ);

  logic [W:0] idx;

  // Scan from farthest to nearest so the first valid at/after prio wins last.
  always_comb begin
    idx         = '0;
    winner_o    = '0;
    any_valid_o = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, prio_i} + (W + 1)'(k);
      if (idx >= (W + 1)'(NUM_REQ)) idx = idx - (W + 1)'(NUM_REQ);
      if (valid_i[idx[W-1:0]]) begin
        winner_o    = idx[W-1:0];
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// rtl/cbus_arbiter.sv - burst-locked round-robin arbiter for N cache-bus masters
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  cbus_req_t                  ireqs  [NUM_REQ],
  output cbus_resp_t                 iresps [NUM_REQ],
  output cbus_req_t                  oreq,
  input  cbus_resp_t                 oresp,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner
);

  localparam int W = $clog2(NUM_REQ);

  arb_state_t   state_q, state_d;
  logic [W-1:0] owner_q, owner_d;
  logic [W-1:0] prio_q,  prio_d;

  logic [NUM_REQ-1:0] valid_vec;
  logic [W-1:0]       winner;
  logic               any_valid;

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) valid_vec[i] = ireqs[i].valid;
  end

  cbus_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .valid_i     (valid_vec),
    .prio_i      (prio_q),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

  // Grant is held until the downstream completes the burst, whatever the masters do.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          state_d = ST_GRANT;
          owner_d = winner;
        end
      end
      ST_GRANT: begin
        if (oresp.ready && oresp.last) begin
          state_d = ST_IDLE;
          prio_d  = (owner_q == W'(NUM_REQ - 1)) ? '0 : owner_q + W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      prio_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end

  always_comb begin
    oreq = '0;
    if (state_q == ST_GRANT) oreq = ireqs[owner_q];
    for (int i = 0; i < NUM_REQ; i++) begin
      iresps[i] = '0;
      if (state_q == ST_GRANT && owner_q == W'(i)) iresps[i] = oresp;
    end
  end

  assign busy  = (state_q == ST_GRANT);
  assign owner = owner_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// tb/tb_cbus_arbiter.sv - directed bench with grant-level reference model
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  localparam int N = 2;

  logic       clk    = 1'b0;
  logic       resetn = 1'b0;
  cbus_req_t  ireqs  [N];
  cbus_resp_t iresps [N];
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  logic       busy;
  logic [0:0] owner;

  always #5 clk = ~clk;

  cbus_arbiter #(.NUM_REQ(N)) dut (
    .clk    (clk),
    .resetn (resetn),
    .ireqs  (ireqs),
    .iresps (iresps),
    .oreq   (oreq),
    .oresp  (oresp),
    .busy   (busy),
    .owner  (owner)
  );

  int vecs = 0;
  int errs = 0;
  int beats_seen0 = 0;

  // Reference: who holds the bus, and whose turn is next.
  logic m_busy  = 1'b0;
  int   m_owner = 0;
  int   m_prio  = 0;

  function automatic int pick(int p);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (p + k) % N;
      if (ireqs[idx].valid) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy  <= 1'b0;
      m_owner <= 0;
      m_prio  <= 0;
    end else if (!m_busy) begin
      if (pick(m_prio) >= 0) begin
        m_busy  <= 1'b1;
        m_owner <= pick(m_prio);
      end
    end else if (oresp.ready && oresp.last) begin
      m_busy <= 1'b0;
      m_prio <= (m_owner + 1) % N;
    end
  end

  task automatic chk(input string nm, input logic [150:0] act, input logic [150:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    if (m_busy) chk("owner", owner, m_owner);
    chk("oreq", oreq, m_busy ? ireqs[m_owner] : cbus_req_t'('0));
    for (int i = 0; i < N; i++)
      chk($sformatf("iresps%0d", i), iresps[i],
          (m_busy && m_owner == i) ? oresp : cbus_resp_t'('0));
    if (iresps[0].ready) beats_seen0++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    for (int i = 0; i < N; i++) ireqs[i] = '0;
    oresp = '0;
    step();
    step();
    resetn = 1'b1;
  endtask

  function automatic cbus_req_t mkreq(bit wr, logic [63:0] addr, mlen_t len);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = wr;
    r.addr     = addr;
    r.size     = MSIZE8;
    r.strobe   = wr ? 8'hff : 8'h00;
    r.data     = wr ? {32'hcafe_0000, addr[31:0]} : 64'h0;
    r.len      = len;
    r.burst    = AXI_BURST_INCR;
    return r;
  endfunction

  task automatic burst(input int n);
    for (int b = 0; b < n; b++) begin
      oresp.ready = 1'b1;
      oresp.last  = (b == n - 1);
      oresp.data  = {$urandom, $urandom};
      step();
    end
    oresp = '0;
  endtask

  int exp_seq [6] = '{0, 1, 0, 1, 0, 1};

  initial begin
    for (int i = 0; i < N; i++) ireqs[i] = '0;
    oresp = '0;
    do_reset();
    chk("rst_busy", busy, 1'b0);
    chk("rst_oreq", oreq, '0);

    // Single master, 16-beat read
    ireqs[0] = mkreq(1'b0, 64'h8000_0000, MLEN16);
    #2 chk("t1_valid_before", oreq.valid, 1'b0);
    step();
    chk("t1_valid_after", oreq.valid, 1'b1);
    chk("t1_addr", oreq.addr, 64'h8000_0000);
    beats_seen0 = 0;
    burst(16);
    ireqs[0] = '0;
    chk("t1_busy_done", busy, 1'b0);
    step();
    chk("t1_beats", beats_seen0, 16);

    // Simultaneous requests
    do_reset();
    ireqs[0] = mkreq(1'b0, 64'h8000_0100, MLEN4);
    ireqs[1] = mkreq(1'b0, 64'h1000_0200, MLEN4);
    step();
    chk("t2_first", owner, 1'b0);
    burst(4);
    ireqs[0] = '0;
    chk("t2_idle_gap", busy, 1'b0);
    step();
    chk("t2_second", owner, 1'b1);
    burst(4);
    ireqs[0] = mkreq(1'b0, 64'h8000_0300, MLEN1);
    step();
    chk("t2_prio_back", owner, 1'b0);
    burst(1);
    ireqs[0] = '0;
    ireqs[1] = '0;

    // Lock during an 8-beat write
    do_reset();
    ireqs[0] = mkreq(1'b1, 64'h8000_1000, MLEN8);
    step();
    ireqs[1] = mkreq(1'b0, 64'h1000_2000, MLEN2);
    for (int b = 0; b < 8; b++) begin
      oresp.ready = 1'b1;
      oresp.last  = (b == 7);
      oresp.data  = {$urandom, $urandom};
      #2;
      chk("t3_ir1_ready", iresps[1].ready, 1'b0);
      chk("t3_addr", oreq.addr, 64'h8000_1000);
      step();
    end
    oresp = '0;
    ireqs[0] = '0;
    step();
    chk("t3_next_owner", owner, 1'b1);
    burst(2);
    ireqs[1] = '0;

    // Fairness with both masters always requesting
    do_reset();
    ireqs[0] = mkreq(1'b0, 64'h8000_4000, MLEN2);
    ireqs[1] = mkreq(1'b0, 64'h1000_4000, MLEN2);
    for (int g = 0; g < 6; g++) begin
      step();
      chk($sformatf("t4_grant%0d", g), owner, exp_seq[g]);
      burst(2);
    end
    ireqs[0] = '0;
    ireqs[1] = '0;

    // Reset mid-burst, then owner dropping valid mid-burst
    do_reset();
    ireqs[0] = mkreq(1'b0, 64'h8000_0000, MLEN16);
    step();
    for (int b = 0; b < 4; b++) begin
      oresp.ready = 1'b1;
      oresp.last  = 1'b0;
      oresp.data  = {$urandom, $urandom};
      step();
    end
    oresp.ready = 1'b1;
    ireqs[1] = mkreq(1'b0, 64'h1000_0000, MLEN4);
    #2 resetn = 1'b0;
    #1;
    chk("t5_rst_valid", oreq.valid, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    oresp = '0;
    step();
    step();
    resetn = 1'b1;
    step();
    chk("t5_after_rst", owner, 1'b0);
    burst(0);
    oresp.ready = 1'b1;
    oresp.data  = {$urandom, $urandom};
    step();
    oresp = '0;
    ireqs[0].valid = 1'b0;
    #2;
    chk("t5_drop_busy", busy, 1'b1);
    chk("t5_drop_valid", oreq.valid, 1'b0);
    step();
    burst(1);
    step();
    chk("t5_next", owner, 1'b1);
    burst(4);
    ireqs[1] = '0;

    // Stray response while idle
    do_reset();
    ireqs[0] = mkreq(1'b0, 64'h8000_5000, MLEN1);
    step();
    burst(1);
    ireqs[0] = '0;
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    oresp.data  = 64'hdead_beef_0000_0001;
    #2 chk("t6_ir0", iresps[0], '0);
    step();
    step();
    chk("t6_idle", busy, 1'b0);
    oresp = '0;
    ireqs[0] = mkreq(1'b0, 64'h8000_6000, MLEN1);
    ireqs[1] = mkreq(1'b0, 64'h1000_6000, MLEN1);
    step();
    chk("t6_prio_kept", owner, 1'b1);
    burst(1);
    ireqs[0] = '0;
    ireqs[1] = '0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/cbus_arbiter.md
CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of cache-bus masters sharing one memory port; legal range 2..4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 ireqs  input  NUM_REQ x cbus_req_t (151 b each)  per-master burst requests; index 0 = icache, 1 = dcache.
REQ-005 iresps  output  NUM_REQ x cbus_resp_t (66 b each)  per-master responses.
REQ-006 oreq  output  cbus_req_t  request to the shared downstream cbus.
REQ-007 oresp  input  cbus_resp_t  response from the downstream cbus.
REQ-008 busy  output  1  high while a grant is held.
REQ-009 owner  output  $clog2(NUM_REQ)  index of the granted master; valid only when busy=1.

Function
REQ-010 FSM has exactly two states: IDLE and GRANT.
REQ-011 IDLE: if any ireqs[i].valid, the arbiter selects one master by round-robin starting at pointer prio, registers it as owner, and enters GRANT on the next edge.
REQ-012 IDLE: oreq is all-zero (valid=0), and every iresps[i] is all-zero.
REQ-013 GRANT: oreq equals ireqs[owner] field for field, combinationally.
REQ-014 GRANT: iresps[owner] equals oresp; every non-owner iresps[j] is all-zero, ready=0.
REQ-015 Latency: oreq.valid rises exactly 1 cycle after the winning ireqs.valid is sampled in IDLE.
REQ-016 GRANT exits to IDLE on the edge where oresp.ready=1 and oresp.last=1; on that edge prio := (owner+1) mod NUM_REQ.
REQ-017 Grant is locked for the whole burst: no re-arbitration in GRANT regardless of other valid inputs.
REQ-018 If ireqs[owner].valid drops in GRANT before last, the arbiter stays in GRANT and forwards valid=0; release still only on ready&last.
REQ-019 oresp.ready while in IDLE is ignored and not forwarded.
REQ-020 Simultaneous requests: winner is the first valid index at or after prio, wrapping modulo NUM_REQ.
REQ-021 Masters may not observe iresps.last before their own request is forwarded; a master cannot be granted twice in a row while another master's valid is held high.
REQ-022 An owner keeping valid high after its last beat is treated as a new request and competes in the next IDLE cycle at lowest priority.

Reset
REQ-023 resetn low asynchronously forces state=IDLE, owner=0, prio=0, busy=0, oreq=0, all iresps=0.
REQ-024 Reset asserted mid-burst abandons the burst; after release the arbiter arbitrates afresh from prio=0.

Structure
REQ-025 cbus_req_t, cbus_resp_t, msize_t, mlen_t and axi_burst_type_t are taken from the shared common package; the FSM state enum and NUM_REQ default live in the same package.
REQ-026 One sub-module, rr_picker (combinational: valid vector + prio -> winner index + any_valid), is natural; all registers stay in cbus_arbiter.

Verification
REQ-027 Single master: ireqs[0] valid, addr=0x8000_0000, len=MLEN16 -> oreq.valid 1 cycle later, 16 ready beats forwarded to iresps[0], busy drops after the beat with last=1.
REQ-028 Simultaneous: both valid after reset -> master 0 granted first; after its last, master 1 granted on the next IDLE cycle; prio then 0.
REQ-029 Lock: master 1 asserts valid during master 0's 8-beat write burst -> oreq stays master 0's fields for all 8 beats; iresps[1].ready stays 0 throughout.
REQ-030 Fairness: both masters hold valid continuously for 6 bursts -> grant sequence 0,1,0,1,0,1.
REQ-031 Reset mid-burst: resetn low at beat 5 of 16 -> oreq.valid=0 and busy=0 immediately (same cycle, asynchronously); after release the first grant goes to master 0.
REQ-032 Stray response: oresp.ready=1 with last=1 while in IDLE -> no iresps activity, state stays IDLE, prio unchanged.
